// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared decode constants, ALU op encodings, ID/EX FSM state
// encoding and the packed control word carried from ID into EX.
package mips_ctrl_pkg;

  // Primary opcodes of the instructions the decoder understands.
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // alu_op encodings seen by the ALU control unit.
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_RTYPE = 2'd2;

  // ID/EX sequencing: normal flow, one-cycle load-use stall, flush shadow.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  // Zero the fields the decoder leaves as don't-care so no X reaches EX.
  // The conditions look at the raw decoder bits on purpose.
  function automatic ctrl_word_t sanitize_ctrl(input ctrl_word_t raw);
    ctrl_word_t w;
    w = raw;
    if (raw.jump) begin
      w.reg_write = 1'b0;
      w.mem_read  = 1'b0;
      w.mem_write = 1'b0;
      w.branch    = 1'b0;
      w.alu_op    = ALU_ADD;
    end
    if (raw.mem_write | raw.branch) begin
      w.reg_dst   = 1'b0;
      w.mem_2_reg = 1'b0;
    end
    return w;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detection between the load sitting
// in EX and the instruction currently in ID, plus the IF/ID hold request.
module hazard_detect
  import mips_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_reg_dst,
  input  logic             id_branch,
  input  logic             id_mem_write,
  input  logic             in_run,
  input  logic             flush,
  output logic             lu,
  output logic             stall_if
);

  logic rt_is_source;

  // rt is only read as a source by R-type, branches and stores.
  assign rt_is_source = id_reg_dst | id_branch | id_mem_write;

  // A load into $0 never creates a dependency.
  assign lu = ex_mem_read & (ex_rt != '0) &
              ((ex_rt == id_rs) | ((ex_rt == id_rt) & rt_is_source));

  // A flush kills the ID instruction, so there is nothing to hold for.
  assign stall_if = lu & in_run & ~flush;

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe: ID/EX register for the decoded control word and register
// indices. Inserts one bubble per load-use hazard and FLUSH_DEPTH bubbles per
// flush request. Optional saturating cause counters: define ID_EX_STATS_EN.
module id_ex_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int FLUSH_DEPTH = 1
`ifdef ID_EX_STATS_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [1:0]       id_alu_op,
  input  logic             id_reg_dst,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_2_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_jump,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush,
  output logic [1:0]       ex_alu_op,
  output logic             ex_reg_dst,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_2_reg,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic             ex_jump,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic [REG_W-1:0] ex_rd,
  output logic             stall_if,
  output logic             bubble
`ifdef ID_EX_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Bubbles still owed after the flush edge itself (FLUSH_DEPTH is 1..3).
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_DEPTH - 1);

  ctrl_word_t  id_word;
  ctrl_word_t  id_clean;
  ctrl_word_t  ex_word;
  pipe_state_t state;
  logic [1:0]  flush_left;
  logic        lu;
  logic        flush_bubble;
  logic        lu_bubble;

  assign id_word = '{alu_op:    id_alu_op,
                     reg_dst:   id_reg_dst,
                     branch:    id_branch,
                     mem_read:  id_mem_read,
                     mem_2_reg: id_mem_2_reg,
                     mem_write: id_mem_write,
                     alu_src:   id_alu_src,
                     reg_write: id_reg_write,
                     jump:      id_jump};

  assign id_clean = sanitize_ctrl(id_word);

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .ex_mem_read  (ex_word.mem_read),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_reg_dst   (id_reg_dst),
    .id_branch    (id_branch),
    .id_mem_write (id_mem_write),
    .in_run       (state == ST_RUN),
    .flush        (flush),
    .lu           (lu),
    .stall_if     (stall_if)
  );

  // The FLUSH cycle whose counter has reached zero is the exit cycle: it
  // captures normally, so a flush costs exactly FLUSH_DEPTH bubbles.
  assign flush_bubble = flush | ((state == ST_FLUSH) & (flush_left != 2'd0));
  assign lu_bubble    = lu & ~flush_bubble;

  // Sequencing FSM together with the registered control word and indices.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex_word    <= CTRL_NOP;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      bubble     <= 1'b1;
      state      <= ST_RUN;
      flush_left <= 2'd0;
    end else if (enable) begin
      if (flush_bubble || lu_bubble) begin
        ex_word <= CTRL_NOP;
        ex_rs   <= '0;
        ex_rt   <= '0;
        ex_rd   <= '0;
        bubble  <= 1'b1;
      end else begin
        ex_word <= id_clean;
        ex_rs   <= id_rs;
        ex_rt   <= id_rt;
        ex_rd   <= id_rd;
        bubble  <= 1'b0;
      end

      if (flush) begin
        state      <= ST_FLUSH;
        flush_left <= FLUSH_LOAD;
      end else begin
        case (state)
          ST_RUN: begin
            if (lu) state <= ST_LU_STALL;
          end
          ST_LU_STALL: begin
            state <= ST_RUN;
          end
          ST_FLUSH: begin
            if (flush_left == 2'd0) state <= ST_RUN;
            else                    flush_left <= flush_left - 2'd1;
          end
          default: begin
            state <= ST_RUN;
          end
        endcase
      end
    end
  end

  assign ex_alu_op    = ex_word.alu_op;
  assign ex_reg_dst   = ex_word.reg_dst;
  assign ex_branch    = ex_word.branch;
  assign ex_mem_read  = ex_word.mem_read;
  assign ex_mem_2_reg = ex_word.mem_2_reg;
  assign ex_mem_write = ex_word.mem_write;
  assign ex_alu_src   = ex_word.alu_src;
  assign ex_reg_write = ex_word.reg_write;
  assign ex_jump      = ex_word.jump;

`ifdef ID_EX_STATS_EN
  // Saturating per-cause bubble counters; only enabled cycles count.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (enable) begin
      if (lu_bubble && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_bubble && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// tb_id_ex_ctrl_pipe: directed scenarios plus randomized traffic for the
// ID/EX control pipe, checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_id_ex_ctrl_pipe;
  import mips_ctrl_pkg::*;

  localparam int REG_W       = 5;
  localparam int FLUSH_DEPTH = 2;
  localparam int OUT_W       = 10 + 3 * REG_W + 1;
`ifdef ID_EX_STATS_EN
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic arst_n, enable, flush;
  logic [1:0] id_alu_op;
  logic id_reg_dst, id_branch, id_mem_read, id_mem_2_reg;
  logic id_mem_write, id_alu_src, id_reg_write, id_jump;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic [1:0] ex_alu_op;
  logic ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg;
  logic ex_mem_write, ex_alu_src, ex_reg_write, ex_jump;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_rd;
  logic stall_if, bubble;
`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_ctrl_pipe #(
    .REG_W       (REG_W),
    .FLUSH_DEPTH (FLUSH_DEPTH)
`ifdef ID_EX_STATS_EN
    ,
    .CNT_W       (CNT_W)
`endif
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .enable       (enable),
    .id_alu_op    (id_alu_op),
    .id_reg_dst   (id_reg_dst),
    .id_branch    (id_branch),
    .id_mem_read  (id_mem_read),
    .id_mem_2_reg (id_mem_2_reg),
    .id_mem_write (id_mem_write),
    .id_alu_src   (id_alu_src),
    .id_reg_write (id_reg_write),
    .id_jump      (id_jump),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .flush        (flush),
    .ex_alu_op    (ex_alu_op),
    .ex_reg_dst   (ex_reg_dst),
    .ex_branch    (ex_branch),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_2_reg (ex_mem_2_reg),
    .ex_mem_write (ex_mem_write),
    .ex_alu_src   (ex_alu_src),
    .ex_reg_write (ex_reg_write),
    .ex_jump      (ex_jump),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .stall_if     (stall_if),
    .bubble       (bubble)
`ifdef ID_EX_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] exp_v;
  logic exp_stall;

  // Model of what sits in EX: control bits
  // {alu_op[1:0], reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump}.
  logic [9:0]       m_ctrl;
  logic [REG_W-1:0] m_rs, m_rt, m_rd;
  logic             m_bubble;
  int               m_flush_owed;
  int               m_stall_cnt, m_flush_cnt;

  function automatic logic [OUT_W-1:0] actual_vec();
    return {ex_alu_op, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg,
            ex_mem_write, ex_alu_src, ex_reg_write, ex_jump, ex_rs, ex_rt, ex_rd, bubble};
  endfunction

  // Decoder word with its don't-cares cleared.
  function automatic logic [9:0] model_clean();
    logic [9:0] w;
    logic       store_or_branch;
    store_or_branch = id_mem_write | id_branch;
    w = {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg,
         id_mem_write, id_alu_src, id_reg_write, id_jump};
    if (id_jump)         w = w & 10'b00_1001_0101;
    if (store_or_branch) w = w & 10'b11_0110_1111;
    return w;
  endfunction

  // Does the instruction in ID read the register the load in EX writes?
  function automatic logic model_lu();
    logic reads_rt;
    reads_rt = id_reg_dst | id_branch | id_mem_write;
    return m_ctrl[5] && (m_rt != 0) &&
           ((m_rt == id_rs) || ((m_rt == id_rt) && reads_rt));
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_bubble = 1'b1;
    m_flush_owed = 0; m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  // Advance the model by one edge, queue the expected EX view, then clock.
  task automatic step();
    logic lu_now;
    logic insert;
    if (enable) begin
      lu_now = model_lu();
      insert = 1'b1;
      if (flush) begin
        m_flush_owed = FLUSH_DEPTH - 1;
        m_flush_cnt  = m_flush_cnt + 1;
      end else if (m_flush_owed > 0) begin
        m_flush_owed = m_flush_owed - 1;
        m_flush_cnt  = m_flush_cnt + 1;
      end else if (lu_now) begin
        m_stall_cnt = m_stall_cnt + 1;
      end else begin
        insert = 1'b0;
      end
`ifdef ID_EX_STATS_EN
      if (m_stall_cnt > CNT_MAX) m_stall_cnt = CNT_MAX;
      if (m_flush_cnt > CNT_MAX) m_flush_cnt = CNT_MAX;
`endif
      if (insert) begin
        m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_bubble = 1'b1;
      end else begin
        m_ctrl = model_clean(); m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_bubble = 1'b0;
      end
    end
    exp_q.push_back({m_ctrl, m_rs, m_rt, m_rd, m_bubble});
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive_instr(input logic [5:0] op, input int rs, input int rt, input int rd);
    logic [7:0] r;
    r = 8'($urandom);
    id_rs = REG_W'(rs);
    id_rt = REG_W'(rt);
    id_rd = REG_W'(rd);
    // {alu_op, reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump}
    case (op)
      OP_R:    {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump} = {ALU_RTYPE, 8'b1000_0010};
      OP_ADDI: {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump} = {ALU_ADD, 8'b0000_0110};
      OP_LW:   {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump} = {ALU_ADD, 8'b0011_0110};
      OP_SW:   {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump} = {ALU_ADD, r[0], 2'b00, r[1], 4'b1100};
      OP_BEQ:  {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump} = {ALU_SUB, r[0], 2'b10, r[1], 4'b0000};
      default: {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump} = {r[1:0], r[7:2], 1'b1};
    endcase
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst_n = 1'b0; enable = 1'b0; flush = 1'b0;
    drive_instr(OP_R, 0, 0, 0);
    model_reset();
    #12;
    exp_v = {m_ctrl, m_rs, m_rt, m_rd, m_bubble};
    total_cnt++;
    if (actual_vec() !== exp_v) $display("FAIL reset_state: got %h expected %h", actual_vec(), exp_v);
    else pass_cnt++;
    total_cnt++;
    if (stall_if !== 1'b0) $display("FAIL reset_stall_if: got %b expected 0", stall_if);
    else pass_cnt++;
`ifdef ID_EX_STATS_EN
    total_cnt++;
    if ({stall_cnt, flush_cnt} !== '0) $display("FAIL reset_counters: got %h/%h expected 0/0", stall_cnt, flush_cnt);
    else pass_cnt++;
`endif
    arst_n = 1'b1; enable = 1'b1;
  endtask

  task automatic test_load_use();
    drive_instr(OP_LW, 9, 8, 0);
    step();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (actual_vec() !== exp_v) $display("FAIL lu_load_capture: got %h expected %h", actual_vec(), exp_v);
    else pass_cnt++;
    drive_instr(OP_R, 8, 10, 9);
    #1;
    exp_stall = model_lu() & ~flush;
    total_cnt++;
    if (stall_if !== exp_stall || stall_if !== 1'b1) $display("FAIL lu_stall_if: got %b expected %b", stall_if, exp_stall);
    else pass_cnt++;
    step();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (actual_vec() !== exp_v) $display("FAIL lu_bubble: got %h expected %h", actual_vec(), exp_v);
    else pass_cnt++;
    total_cnt++;
    if (stall_if !== 1'b0) $display("FAIL lu_stall_released: got %b expected 0", stall_if);
    else pass_cnt++;
    step();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (actual_vec() !== exp_v) $display("FAIL lu_add_capture: got %h expected %h", actual_vec(), exp_v);
    else pass_cnt++;
    total_cnt++;
    if ({ex_reg_write, ex_reg_dst, ex_alu_op} !== {1'b1, 1'b1, ALU_RTYPE})
      $display("FAIL lu_add_ctrl: got %b%b%h expected 112", ex_reg_write, ex_reg_dst, ex_alu_op);
    else pass_cnt++;
`ifdef ID_EX_STATS_EN
    total_cnt++;
    if (stall_cnt !== CNT_W'(m_stall_cnt)) $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, m_stall_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_stall();
    drive_instr(OP_LW, 3, 8, 0);
    step();
    void'(exp_q.pop_front());
    drive_instr(OP_R, 8, 2, 4);
    step();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (actual_vec() !== exp_v) $display("FAIL rst_mid_bubble: got %h expected %h", actual_vec(), exp_v);
    else pass_cnt++;
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    exp_v = {m_ctrl, m_rs, m_rt, m_rd, m_bubble};
    total_cnt++;
    if (actual_vec() !== exp_v) $display("FAIL rst_mid_async: got %h expected %h", actual_vec(), exp_v);
    else pass_cnt++;
    #1 arst_n = 1'b1;
    step();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (actual_vec() !== exp_v) $display("FAIL rst_mid_resume: got %h expected %h", actual_vec(), exp_v);
    else pass_cnt++;
    drive_instr(OP_LW, 1, 6, 0);
    step();
    void'(exp_q.pop_front());
    drive_instr(OP_BEQ, 5, 6, 0);
    #1;
    exp_stall = model_lu() & ~flush;
    total_cnt++;
    if (stall_if !== exp_stall) $display("FAIL rst_mid_run_stall: got %b expected %b", stall_if, exp_stall);
    else pass_cnt++;
    step();
    void'(exp_q.pop_front());
    step();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (actual_vec() !== exp_v) $display("FAIL rst_mid_beq_capture: got %h expected %h", actual_vec(), exp_v);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    drive_instr(OP_LW, 4, 0, 0);
    step();
    void'(exp_q.pop_front());
    drive_instr(OP_R, 0, 0, 7);
    #1;
    exp_stall = model_lu() & ~flush;
    total_cnt++;
    if (stall_if !== exp_stall || stall_if !== 1'b0) $display("FAIL zero_no_stall: got %b expected %b", stall_if, exp_stall);
    else pass_cnt++;
    step();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (actual_vec() !== exp_v) $display("FAIL zero_capture: got %h expected %h", actual_vec(), exp_v);
    else pass_cnt++;
    drive_instr(OP_LW, 4, 8, 0);
    step();
    void'(exp_q.pop_front());
    drive_instr(OP_SW, 5, 8, 0);
    #1;
    exp_stall = model_lu() & ~flush;
    total_cnt++;
    if (stall_if !== exp_stall || stall_if !== 1'b1) $display("FAIL sw_data_stall: got %b expected %b", stall_if, exp_stall);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (actual_vec() !== exp_v) $display("FAIL sw_seq_%0d: got %h expected %h", i, actual_vec(), exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    drive_instr(OP_R, 1, 2, 3);
    flush = 1'b1;
    for (int i = 0; i < FLUSH_DEPTH + 1; i++) begin
      #1;
      total_cnt++;
      if (stall_if !== 1'b0) $display("FAIL flush_stall_if_%0d: got %b expected 0", i, stall_if);
      else pass_cnt++;
      step();
      flush = 1'b0;
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (actual_vec() !== exp_v) $display("FAIL flush_seq_%0d: got %h expected %h", i, actual_vec(), exp_v);
      else pass_cnt++;
    end
    drive_instr(OP_LW, 4, 8, 0);
    step();
    void'(exp_q.pop_front());
    drive_instr(OP_R, 8, 5, 6);
    flush = 1'b1;
    #1;
    total_cnt++;
    if (stall_if !== 1'b0) $display("FAIL flush_lu_stall_if: got %b expected 0", stall_if);
    else pass_cnt++;
    for (int i = 0; i < FLUSH_DEPTH + 1; i++) begin
      step();
      flush = 1'b0;
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (actual_vec() !== exp_v) $display("FAIL flush_lu_seq_%0d: got %h expected %h", i, actual_vec(), exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_jump_sanitize();
    for (int i = 0; i < 2; i++) begin
      drive_instr(OP_J, 3, 4, 5);
      id_reg_write = (i == 0) ? 1'bx : 1'b1;
      id_mem_write = (i == 0) ? 1'bx : 1'b1;
      step();
      exp_v = exp_q.pop_front();
      total_cnt++;
      if ({ex_reg_write, ex_mem_write, ex_jump} !== 3'b001)
        $display("FAIL jump_clean_%0d: got %b%b%b expected 001", i, ex_reg_write, ex_mem_write, ex_jump);
      else pass_cnt++;
      total_cnt++;
      if (actual_vec() !== exp_v) $display("FAIL jump_word_%0d: got %h expected %h", i, actual_vec(), exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_hold();
    drive_instr(OP_LW, 1, 8, 0);
    step();
    void'(exp_q.pop_front());
    drive_instr(OP_R, 8, 3, 4);
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_stall = model_lu() & ~flush;
      total_cnt++;
      if (stall_if !== exp_stall) $display("FAIL hold_run_stall_%0d: got %b expected %b", i, stall_if, exp_stall);
      else pass_cnt++;
      step();
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (actual_vec() !== exp_v) $display("FAIL hold_run_%0d: got %h expected %h", i, actual_vec(), exp_v);
      else pass_cnt++;
    end
    enable = 1'b1;
    step();
    void'(exp_q.pop_front());
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (actual_vec() !== exp_v || stall_if !== 1'b0)
        $display("FAIL hold_stall_%0d: got %h/%b expected %h/0", i, actual_vec(), stall_if, exp_v);
      else pass_cnt++;
    end
    enable = 1'b1;
    step();
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (actual_vec() !== exp_v) $display("FAIL hold_resume: got %h expected %h", actual_vec(), exp_v);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    for (int i = 0; i < 400; i++) begin
      drive_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31));
      flush  = ($urandom_range(0, 9) == 0);
      enable = ($urandom_range(0, 9) != 0);
      #1;
      exp_stall = model_lu() & ~flush;
      total_cnt++;
      if (stall_if !== exp_stall) $display("FAIL rand_stall_if_%0d: got %b expected %b", i, stall_if, exp_stall);
      else pass_cnt++;
      step();
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (actual_vec() !== exp_v) $display("FAIL rand_word_%0d: got %h expected %h", i, actual_vec(), exp_v);
      else pass_cnt++;
    end
    flush = 1'b0;
    enable = 1'b1;
`ifdef ID_EX_STATS_EN
    total_cnt++;
    if (stall_cnt !== CNT_W'(m_stall_cnt) || flush_cnt !== CNT_W'(m_flush_cnt))
      $display("FAIL rand_counters: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
    else pass_cnt++;
`endif
  endtask

`ifdef ID_EX_STATS_EN
  task automatic test_stats_saturate();
    drive_instr(OP_ADDI, 1, 2, 3);
    flush = 1'b1;
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      step();
      void'(exp_q.pop_front());
      total_cnt++;
      if (flush_cnt !== CNT_W'(m_flush_cnt)) $display("FAIL flush_cnt_%0d: got %0d expected %0d", i, flush_cnt, m_flush_cnt);
      else pass_cnt++;
    end
    flush = 1'b0;
    for (int i = 0; i < FLUSH_DEPTH; i++) begin
      step();
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      drive_instr(OP_LW, 1, 8, 0);
      step();
      void'(exp_q.pop_front());
      drive_instr(OP_R, 8, 8, 2);
      step();
      void'(exp_q.pop_front());
      step();
      void'(exp_q.pop_front());
    end
    total_cnt++;
    if (stall_cnt !== CNT_W'(m_stall_cnt) || m_stall_cnt != CNT_MAX)
      $display("FAIL stall_cnt_sat: got %0d expected %0d", stall_cnt, CNT_MAX);
    else pass_cnt++;
    total_cnt++;
    if (flush_cnt !== CNT_W'(CNT_MAX)) $display("FAIL flush_cnt_sat: got %0d expected %0d", flush_cnt, CNT_MAX);
    else pass_cnt++;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load_use();
    test_reset_mid_stall();
    test_zero_reg();
    test_flush();
    test_jump_sanitize();
    test_enable_hold();
    test_random();
`ifdef ID_EX_STATS_EN
    test_stats_saturate();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected finish before 500000ns");
    $fatal(1, "simulation time limit reached");
  end

endmodule
